// File: rtl/encode_lsps_scalar.sv
// -----------------------------------------------------------------------------
// encode_lsps_scalar
//   Scalar LSP quantiser for the 2400 bit/s encoder. It latches ten unquantised
//   LSPs (radians, Q16.16) and converts each one to Hz. It then searches each
//   LSP's codebook, stored in an external synchronous ROM, for the nearest
//   entry (squared error, lowest index wins ties). The result is 10 indices,
//   36 bits in total.
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous reset, active low
//   start_lsps  start request, level-sampled in IDLE (and in DONE for release)
//   lsp0..lsp9  unquantised LSPs, rad Q16.16, sampled only in LATCH
//   cb_addr     codebook ROM address (registered)
//   cb_data     ROM word, Hz Q16.16, valid the cycle after cb_addr changes
//   idx0..idx6  4-bit indices for LSPs 0..6
//   idx7, idx8  3-bit indices for LSPs 7, 8
//   idx9        2-bit index for LSP 9
//   done_lsps   high while the result is held in DONE
//
// Codebook map (k = LSP number):
//   size 16 for k<=6, 8 for k=7,8, 4 for k=9
//   base 16k for k<=7, 120 for k=8, 128 for k=9 (132 words)
// -----------------------------------------------------------------------------
module encode_lsps_scalar #(
    parameter int          N        = 32,
    parameter int          Q        = 16,
    parameter logic [31:0] SCALE_HZ = 32'd83443025  // 4000/pi, Q16.16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_lsps,
    input  logic [N-1:0] lsp0,
    input  logic [N-1:0] lsp1,
    input  logic [N-1:0] lsp2,
    input  logic [N-1:0] lsp3,
    input  logic [N-1:0] lsp4,
    input  logic [N-1:0] lsp5,
    input  logic [N-1:0] lsp6,
    input  logic [N-1:0] lsp7,
    input  logic [N-1:0] lsp8,
    input  logic [N-1:0] lsp9,
    output logic [7:0]   cb_addr,
    input  logic [N-1:0] cb_data,
    output logic [3:0]   idx0,
    output logic [3:0]   idx1,
    output logic [3:0]   idx2,
    output logic [3:0]   idx3,
    output logic [3:0]   idx4,
    output logic [3:0]   idx5,
    output logic [3:0]   idx6,
    output logic [2:0]   idx7,
    output logic [2:0]   idx8,
    output logic [1:0]   idx9,
    output logic         done_lsps
);

    typedef enum logic [2:0] {
        IDLE, LATCH, CONV, INIT, ADDR, CMP, STORE, DONE
    } state_t;

    state_t                state;
    logic [3:0]            k;
    logic [3:0]            j;
    logic [2*N-1:0]        best_err;
    logic [3:0]            best_idx;
    logic signed [N-1:0]   lsp_r [10];
    logic signed [N-1:0]   hz    [10];

    // First codebook address of LSP kk.
    function automatic logic [7:0] cb_base(input logic [3:0] kk);
        if (kk <= 4'd7)      return {kk, 4'b0000};
        else if (kk == 4'd8) return 8'd120;
        else                 return 8'd128;
    endfunction

    // Index of the last codebook entry of LSP kk (size - 1).
    function automatic logic [3:0] cb_last(input logic [3:0] kk);
        if (kk <= 4'd6)      return 4'd15;
        else if (kk <= 4'd8) return 4'd7;
        else                 return 4'd3;
    endfunction

    // rad -> Hz: full signed 64-bit product, keep the Q16.16 window [47:16].
    logic signed [2*N-1:0] lsp_ext;
    logic signed [2*N-1:0] scale_ext;
    logic signed [2*N-1:0] prod;
    assign lsp_ext   = {{N{lsp_r[k][N-1]}}, lsp_r[k]};
    assign scale_ext = {{N{1'b0}}, SCALE_HZ};
    assign prod      = lsp_ext * scale_ext;

    // Squared distance to the current ROM word. The square of a sign-extended
    // value is never negative, so the 2N-bit result is read as unsigned.
    logic signed [N-1:0]   diff;
    logic signed [2*N-1:0] diff_ext;
    logic [2*N-1:0]        err;
    assign diff     = hz[k] - $signed(cb_data);
    assign diff_ext = {{N{diff[N-1]}}, diff};
    assign err      = $unsigned(diff_ext * diff_ext);

    // NOTE: every register here is assigned with <= so all of them update
    // together from values sampled before the edge; a blocking = would let
    // later statements see half-updated state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            k         <= '0;
            j         <= '0;
            best_err  <= '0;
            best_idx  <= '0;
            cb_addr   <= '0;
            done_lsps <= 1'b0;
            idx0 <= '0; idx1 <= '0; idx2 <= '0; idx3 <= '0; idx4 <= '0;
            idx5 <= '0; idx6 <= '0; idx7 <= '0; idx8 <= '0; idx9 <= '0;
            // NOTE: the small hz/lsp arrays are cleared explicitly so a reset
            // mid-run leaves no stale converted values behind. Large RAMs
            // would normally be left unreset.
            for (int i = 0; i < 10; i++) begin
                lsp_r[i] <= '0;
                hz[i]    <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    done_lsps <= 1'b0;
                    if (start_lsps) state <= LATCH;
                end
                LATCH: begin
                    lsp_r[0] <= lsp0; lsp_r[1] <= lsp1; lsp_r[2] <= lsp2;
                    lsp_r[3] <= lsp3; lsp_r[4] <= lsp4; lsp_r[5] <= lsp5;
                    lsp_r[6] <= lsp6; lsp_r[7] <= lsp7; lsp_r[8] <= lsp8;
                    lsp_r[9] <= lsp9;
                    k     <= '0;
                    state <= CONV;
                end
                CONV: begin
                    hz[k] <= prod[N+Q-1:Q];
                    if (k == 4'd9) begin
                        k     <= '0;
                        state <= INIT;
                    end else begin
                        k <= k + 4'd1;
                    end
                end
                INIT: begin
                    j        <= '0;
                    best_err <= '1;
                    best_idx <= '0;
                    cb_addr  <= cb_base(k);
                    state    <= ADDR;
                end
                ADDR: state <= CMP;   // ROM registers cb_addr this cycle
                CMP: begin
                    // Strict compare: on a tie the earlier (lower) index stays.
                    if (err < best_err) begin
                        best_err <= err;
                        best_idx <= j;
                    end
                    if (j == cb_last(k)) begin
                        state <= STORE;
                    end else begin
                        j       <= j + 4'd1;
                        cb_addr <= cb_base(k) + {4'd0, j} + 8'd1;
                        state   <= ADDR;
                    end
                end
                STORE: begin
                    case (k)
                        4'd0:    idx0 <= best_idx;
                        4'd1:    idx1 <= best_idx;
                        4'd2:    idx2 <= best_idx;
                        4'd3:    idx3 <= best_idx;
                        4'd4:    idx4 <= best_idx;
                        4'd5:    idx5 <= best_idx;
                        4'd6:    idx6 <= best_idx;
                        4'd7:    idx7 <= best_idx[2:0];
                        4'd8:    idx8 <= best_idx[2:0];
                        default: idx9 <= best_idx[1:0];
                    endcase
                    if (k == 4'd9) begin
                        done_lsps <= 1'b1;
                        state     <= DONE;
                    end else begin
                        k     <= k + 4'd1;
                        state <= INIT;
                    end
                end
                DONE: begin
                    // Holding start high parks here; one low cycle re-arms.
                    if (!start_lsps) begin
                        done_lsps <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_encode_lsps_scalar.sv
// -----------------------------------------------------------------------------
// tb_encode_lsps_scalar
//   Scoreboard bench for encode_lsps_scalar. It provides a behavioural
//   synchronous codebook ROM. Expected index vectors are queued when a run is
//   started and compared when done_lsps rises. It also checks latency, reset
//   behaviour, the back-to-back start handshake and the cb_addr walk.
// -----------------------------------------------------------------------------
module tb_encode_lsps_scalar;

    localparam logic [31:0] SCALE   = 32'd83443025;
    localparam int          LAT     = 295;
    localparam int          HZ1     = 65536;   // 1 Hz in Q16.16

    typedef logic [9:0][3:0] idx_vec_t;         // element [k] = idx k

    logic        clk = 1'b0;
    logic        rst;
    logic        start_lsps;
    logic [31:0] lsp_in [10];
    logic [7:0]  cb_addr;
    logic [31:0] cb_data;
    logic [3:0]  idx0, idx1, idx2, idx3, idx4, idx5, idx6;
    logic [2:0]  idx7, idx8;
    logic [1:0]  idx9;
    logic        done_lsps;

    logic [31:0] rom [256];
    idx_vec_t    exp_q [$];

    int n_cmp = 0;
    int n_bad = 0;

    encode_lsps_scalar dut (
        .clk        (clk),
        .rst        (rst),
        .start_lsps (start_lsps),
        .lsp0 (lsp_in[0]), .lsp1 (lsp_in[1]), .lsp2 (lsp_in[2]),
        .lsp3 (lsp_in[3]), .lsp4 (lsp_in[4]), .lsp5 (lsp_in[5]),
        .lsp6 (lsp_in[6]), .lsp7 (lsp_in[7]), .lsp8 (lsp_in[8]),
        .lsp9 (lsp_in[9]),
        .cb_addr    (cb_addr),
        .cb_data    (cb_data),
        .idx0 (idx0), .idx1 (idx1), .idx2 (idx2), .idx3 (idx3),
        .idx4 (idx4), .idx5 (idx5), .idx6 (idx6),
        .idx7 (idx7), .idx8 (idx8), .idx9 (idx9),
        .done_lsps  (done_lsps)
    );

    always #5 clk = ~clk;

    // Synchronous codebook ROM: data valid the cycle after the address.
    always @(posedge clk) cb_data <= rom[cb_addr];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int tb_base(input int k);
        if (k <= 7) return 16 * k;
        else if (k == 8) return 120;
        else return 128;
    endfunction

    function automatic int tb_size(input int k);
        if (k <= 6) return 16;
        else if (k <= 8) return 8;
        else return 4;
    endfunction

    function automatic logic [31:0] to_hz(input logic [31:0] l);
        logic signed [63:0] p;
        p = $signed({{32{l[31]}}, l}) * $signed({32'd0, SCALE});
        return p[47:16];
    endfunction

    function automatic idx_vec_t model_now();
        idx_vec_t v;
        for (int k = 0; k < 10; k++) begin
            logic [63:0] best_e;
            int          best_j;
            logic [31:0] h;
            h      = to_hz(lsp_in[k]);
            best_e = '1;
            best_j = 0;
            for (int j = 0; j < tb_size(k); j++) begin
                logic signed [31:0] d;
                logic signed [63:0] d64;
                logic [63:0]        e;
                d   = $signed(h) - $signed(rom[tb_base(k) + j]);
                d64 = d;
                e   = $unsigned(d64 * d64);
                if (e < best_e) begin
                    best_e = e;
                    best_j = j;
                end
            end
            v[k] = 4'(best_j);
        end
        return v;
    endfunction

    function automatic idx_vec_t const_vec(input logic [3:0] a06, input logic [3:0] a78,
                                           input logic [3:0] a9);
        idx_vec_t v;
        for (int k = 0; k < 7; k++) v[k] = a06;
        v[7] = a78;
        v[8] = a78;
        v[9] = a9;
        return v;
    endfunction

    task automatic load_rom_linear();
        for (int a = 0; a < 256; a++) rom[a] = 32'd0;
        for (int k = 0; k < 10; k++)
            for (int j = 0; j < tb_size(k); j++)
                rom[tb_base(k) + j] = 32'(j * 100 * HZ1);
    endtask

    task automatic set_all_lsps(input logic [31:0] v);
        for (int i = 0; i < 10; i++) lsp_in[i] = v;
    endtask

    // ---------------- cb_addr monitor ----------------
    bit          mon_en = 1'b0;
    logic [7:0]  mon_last;
    int          mon_hold;
    logic [7:0]  addr_q [$];
    int          hold_q [$];

    always @(negedge clk) begin
        if (mon_en) begin
            if (cb_addr !== mon_last) begin
                addr_q.push_back(cb_addr);
                hold_q.push_back(mon_hold);
                mon_last = cb_addr;
                mon_hold = 1;
            end else begin
                mon_hold++;
            end
        end
    end

    // ---------------- run helpers ----------------
    // Called shortly after a clock edge with the DUT in IDLE.
    task automatic start_run(input idx_vec_t expected);
        exp_q.push_back(expected);
        start_lsps = 1'b1;
        @(posedge clk); #1;            // edge that samples start in IDLE
    endtask

    // Waits for done, scrambles the lsp inputs once they have been latched,
    // then pops the scoreboard and compares all ten indices.
    task automatic wait_done(input string tag);
        int       cnt;
        idx_vec_t ev;
        cnt = 0;
        while (!done_lsps && cnt < 400) begin
            @(posedge clk); #1;
            cnt++;
            if (cnt == 1)
                for (int i = 0; i < 10; i++) lsp_in[i] = $urandom;
        end
        check({tag, "_latency"}, 64'(cnt), 64'(LAT));
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 64'd1, 64'd0);
        end else begin
            ev = exp_q.pop_front();
            check({tag, "_idx0"}, 64'(idx0), 64'(ev[0]));
            check({tag, "_idx1"}, 64'(idx1), 64'(ev[1]));
            check({tag, "_idx2"}, 64'(idx2), 64'(ev[2]));
            check({tag, "_idx3"}, 64'(idx3), 64'(ev[3]));
            check({tag, "_idx4"}, 64'(idx4), 64'(ev[4]));
            check({tag, "_idx5"}, 64'(idx5), 64'(ev[5]));
            check({tag, "_idx6"}, 64'(idx6), 64'(ev[6]));
            check({tag, "_idx7"}, 64'(idx7), 64'(ev[7]));
            check({tag, "_idx8"}, 64'(idx8), 64'(ev[8]));
            check({tag, "_idx9"}, 64'(idx9), 64'(ev[9]));
        end
    endtask

    task automatic release_start(input string tag);
        start_lsps = 1'b0;
        @(posedge clk); #1;
        check({tag, "_done_low"}, 64'(done_lsps), 64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] hz_t2;
        int          bad_order;
        int          bad_hold;
        int          v;
        logic        last_of_k;

        rst        = 1'b0;
        start_lsps = 1'b0;
        set_all_lsps(32'd0);
        load_rom_linear();
        #12;
        check("reset_done",    64'(done_lsps), 64'd0);
        check("reset_cb_addr", 64'(cb_addr),   64'd0);
        check("reset_idx", 64'({idx0, idx1, idx2, idx3, idx4, idx5, idx6, idx7, idx8, idx9}), 64'd0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // T1: 0.5 rad (636.6 Hz) against a j*100 Hz codebook.
        set_all_lsps(32'h0000_8000);
        start_run(const_vec(4'd6, 4'd6, 4'd3));
        wait_done("t1");
        release_start("t1");

        // T4: reset 150 cycles into a run.
        set_all_lsps(32'h0003_243F);
        start_run(const_vec(4'd15, 4'd7, 4'd3));
        repeat (149) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        void'(exp_q.pop_back());
        check("t4_rst_done",    64'(done_lsps), 64'd0);
        check("t4_rst_cb_addr", 64'(cb_addr),   64'd0);
        check("t4_rst_idx", 64'({idx0, idx1, idx2, idx3, idx4, idx5, idx6, idx7, idx8, idx9}), 64'd0);
        start_lsps = 1'b0;
        @(negedge clk) rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t4_idle_cb_addr", 64'(cb_addr),   64'd0);
        check("t4_idle_done",    64'(done_lsps), 64'd0);
        set_all_lsps(32'h0003_243F);
        start_run(const_vec(4'd15, 4'd7, 4'd3));
        wait_done("t4_restart");
        release_start("t4_restart");

        // T3: zero LSPs select index 0 everywhere.
        set_all_lsps(32'd0);
        start_run(const_vec(4'd0, 4'd0, 4'd0));
        wait_done("t3_zero");
        release_start("t3_zero");

        // T6: cb_addr walk during a run that starts from address 131.
        addr_q.delete();
        hold_q.delete();
        mon_last = cb_addr;
        mon_hold = 0;
        mon_en   = 1'b1;
        set_all_lsps(32'h0000_8000);
        start_run(const_vec(4'd6, 4'd6, 4'd3));
        wait_done("t6");
        mon_en = 1'b0;
        release_start("t6");
        check("t6_addr_changes", 64'(addr_q.size()), 64'd132);
        bad_order = 0;
        bad_hold  = 0;
        for (int i = 0; i < addr_q.size(); i++) begin
            if (addr_q[i] !== 8'(i)) bad_order++;
            if (i + 1 < addr_q.size()) begin
                v = i;
                last_of_k = (v == 15 || v == 31 || v == 47 || v == 63 || v == 79 ||
                             v == 95 || v == 111 || v == 119 || v == 127);
                if (hold_q[i + 1] != (last_of_k ? 4 : 2)) bad_hold++;
            end
        end
        check("t6_addr_order", 64'(bad_order), 64'd0);
        check("t6_addr_hold",  64'(bad_hold),  64'd0);

        // T2: ROM words 50 Hz either side of the converted value -> lower wins.
        set_all_lsps(32'd33457);
        hz_t2 = to_hz(32'd33457);
        for (int k = 0; k < 9; k++) begin
            rom[tb_base(k) + 6] = hz_t2 - 32'(50 * HZ1);
            rom[tb_base(k) + 7] = hz_t2 + 32'(50 * HZ1);
        end
        start_run(const_vec(4'd6, 4'd6, 4'd3));
        wait_done("t2_tie");
        release_start("t2_tie");
        load_rom_linear();

        // T5: start held high keeps DONE; a low cycle then a new run.
        set_all_lsps(32'h0003_243F);
        start_run(const_vec(4'd15, 4'd7, 4'd3));
        wait_done("t5_first");
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("t5_done_held", 64'(done_lsps), 64'd1);
        end
        check("t5_idx_held", 64'(idx0), 64'd15);
        release_start("t5");
        set_all_lsps(32'h0000_8000);
        start_run(const_vec(4'd6, 4'd6, 4'd3));
        wait_done("t5_second");
        release_start("t5_second");

        // Random codebook and LSPs, checked against the model.
        for (int r = 0; r < 3; r++) begin
            for (int a = 0; a < 132; a++) rom[a] = $urandom_range(0, 262144000);
            for (int i = 0; i < 10; i++) lsp_in[i] = $urandom_range(0, 205887);
            start_run(model_now());
            wait_done("rand");
            release_start("rand");
        end

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
